// File: rtl/wb_demux.sv
`default_nettype none
// ============================================================================
//  Module   : wb_demux
//  Purpose  : Write-back router. Steers the ALU result to register A,
//             register B, a store FIFO draining to data memory, or discard.
//             Optional same-cycle store bypass when built with WB_BYPASS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module wb_demux #(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    data,
    input  logic [1:0]    dest,
    input  logic [AW-1:0] addr,
    output logic [7:0]    reg_a,
    output logic [7:0]    reg_b,
    output logic          mem_wr_en,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_data,
    output logic [$clog2(DEPTH):0] store_count,
    output logic          discard_seen
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH) + 1;
    localparam logic [1:0] c_DEST_A   = 2'b00;
    localparam logic [1:0] c_DEST_B   = 2'b01;
    localparam logic [1:0] c_DEST_MEM = 2'b10;
    localparam logic [1:0] c_DEST_DIS = 2'b11;

    logic [AW-1:0]   r_fifo_addr_q [DEPTH];
    logic [7:0]      r_fifo_data_q [DEPTH];
    logic [c_PW-1:0] r_wptr_q, w_wptr_d;
    logic [c_PW-1:0] r_rptr_q, w_rptr_d;
    logic [c_CW-1:0] r_count_q, w_count_d;
    logic [7:0]      r_reg_a_q, w_reg_a_d;
    logic [7:0]      r_reg_b_q, w_reg_b_d;
    logic            r_disc_q, w_disc_d;

    logic w_full, w_nonempty, w_accept, w_store_req, w_bypass, w_push, w_pop;

    assign w_full      = (r_count_q == c_CW'(DEPTH));
    assign w_nonempty  = (r_count_q != '0);
    assign w_accept    = in_valid && !w_full;
    assign w_store_req = w_accept && (dest == c_DEST_MEM);

`ifdef WB_BYPASS_EN
    // Empty FIFO and a ready memory: the store goes straight through.
    assign w_bypass = w_store_req && !w_nonempty && mem_ready && !rst;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_store_req && !w_bypass;
    // A cycle with rst high never completes a memory write.
    assign w_pop  = w_nonempty && mem_ready && !rst;

    assign in_ready     = !w_full;
    assign mem_wr_en    = (w_nonempty && !rst) || w_bypass;
    assign mem_addr     = w_bypass ? addr : r_fifo_addr_q[r_rptr_q];
    assign mem_data     = w_bypass ? data : r_fifo_data_q[r_rptr_q];
    assign store_count  = r_count_q;
    assign reg_a        = r_reg_a_q;
    assign reg_b        = r_reg_b_q;
    assign discard_seen = r_disc_q;

    always_comb begin
        w_reg_a_d = r_reg_a_q;
        w_reg_b_d = r_reg_b_q;
        w_disc_d  = r_disc_q;
        w_wptr_d  = r_wptr_q;
        w_rptr_d  = r_rptr_q;
        w_count_d = r_count_q;
        if (w_accept) begin
            case (dest)
                c_DEST_A:   w_reg_a_d = data;
                c_DEST_B:   w_reg_b_d = data;
                c_DEST_DIS: w_disc_d  = 1'b1;
                default:    ;
            endcase
        end
        if (w_push) w_wptr_d = r_wptr_q + c_PW'(1);
        if (w_pop)  w_rptr_d = r_rptr_q + c_PW'(1);
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + c_CW'(1);
            2'b01:   w_count_d = r_count_q - c_CW'(1);
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_a_q <= '0;
            r_reg_b_q <= '0;
            r_disc_q  <= 1'b0;
            r_wptr_q  <= '0;
            r_rptr_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_reg_a_q <= w_reg_a_d;
            r_reg_b_q <= w_reg_b_d;
            r_disc_q  <= w_disc_d;
            r_wptr_q  <= w_wptr_d;
            r_rptr_q  <= w_rptr_d;
            r_count_q <= w_count_d;
        end
    end

    // Entry storage carries no reset; occupancy is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_fifo_addr_q[r_wptr_q] <= addr;
            r_fifo_data_q[r_wptr_q] <= data;
        end
    end

endmodule
`default_nettype wire
